// File: rtl/readout_cmd_pkg.sv
// Shared definitions for the readout waveform-command FIFO (writer and read side).
package readout_cmd_pkg;

    localparam int FREQ_W   = 32;
    localparam int PHASE_W  = 32;
    localparam int NSAMP_W  = 16;
    localparam int OUTSEL_W = 2;
    localparam int CMD_W    = 83;

    // FIFO entry layout: {mode, outsel, nsamp, phase, freq}
    localparam int FREQ_LSB   = 0;
    localparam int PHASE_LSB  = 32;
    localparam int NSAMP_LSB  = 64;
    localparam int OUTSEL_LSB = 80;
    localparam int MODE_BIT   = 82;

    // Bit positions inside command word 2
    localparam int W2_NSAMP_LSB  = 0;
    localparam int W2_OUTSEL_LSB = 16;
    localparam int W2_MODE_BIT   = 18;

    typedef logic [1:0] state_t;
    localparam state_t ST_W0   = 2'd0;
    localparam state_t ST_W1   = 2'd1;
    localparam state_t ST_W2   = 2'd2;
    localparam state_t ST_PUSH = 2'd3;

endpackage

// File: rtl/readout_cmd_writer.sv
// Packs 3-word processor commands into 83-bit readout FIFO entries with framing/nsamp checks.
// Optional command/drop counters are built when READOUT_CMD_WR_STATS_EN is defined.
module readout_cmd_writer
    import readout_cmd_pkg::*;
#(
    parameter int NSAMP_MIN = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    output logic              s_tready_o,
    output logic              fifo_wr_en_o,
    input  logic              fifo_full_i,
    output logic [CMD_W-1:0]  fifo_din_o,
    input  logic              clr_err_i,
    output logic [1:0]        err_o,
    output logic [31:0]       cmd_cnt_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [NSAMP_W-1:0] NSAMP_MIN_L = NSAMP_W'(NSAMP_MIN);

    state_t                state;
    logic [FREQ_W-1:0]     freq;
    logic [PHASE_W-1:0]    phase;
    logic [NSAMP_W-1:0]    nsamp;
    logic [OUTSEL_W-1:0]   outsel;
    logic                  mode;

    logic                  acc;
    logic [NSAMP_W-1:0]    w2_nsamp;
    logic                  nsamp_bad;
    logic                  frame_err;
    logic                  nsamp_err;

    // Word-2 bits above the mode flag carry no meaning.
    logic unused_w2_bits;
    assign unused_w2_bits = &{1'b0, s_tdata_i[31:W2_MODE_BIT+1]};

    assign s_tready_o   = (state != ST_PUSH);
    assign fifo_wr_en_o = (state == ST_PUSH) & ~fifo_full_i;
    assign fifo_din_o   = {mode, outsel, nsamp, phase, freq};

    assign acc       = s_tvalid_i & s_tready_o;
    assign w2_nsamp  = s_tdata_i[W2_NSAMP_LSB +: NSAMP_W];
    assign nsamp_bad = (w2_nsamp < NSAMP_MIN_L);
    assign frame_err = acc & ((s_tlast_i & ((state == ST_W0) | (state == ST_W1))) |
                              (~s_tlast_i & (state == ST_W2)));
    assign nsamp_err = acc & (state == ST_W2) & nsamp_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_W0;
            freq   <= '0;
            phase  <= '0;
            nsamp  <= '0;
            outsel <= '0;
            mode   <= 1'b0;
        end else begin
            case (state)
                ST_W0: if (acc) begin
                    freq  <= s_tdata_i;
                    state <= s_tlast_i ? ST_W0 : ST_W1;
                end
                ST_W1: if (acc) begin
                    phase <= s_tdata_i;
                    state <= s_tlast_i ? ST_W0 : ST_W2;
                end
                ST_W2: if (acc) begin
                    nsamp  <= w2_nsamp;
                    outsel <= s_tdata_i[W2_OUTSEL_LSB +: OUTSEL_W];
                    mode   <= s_tdata_i[W2_MODE_BIT];
                    state  <= (!s_tlast_i || nsamp_bad) ? ST_W0 : ST_PUSH;
                end
                default: if (!fifo_full_i) state <= ST_W0;
            endcase
        end
    end

    // New errors are OR-ed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_o <= 2'b00;
        else       err_o <= (clr_err_i ? 2'b00 : err_o) | {nsamp_err, frame_err};
    end

`ifdef READOUT_CMD_WR_STATS_EN
    logic drop;
    assign drop = frame_err | nsamp_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (fifo_wr_en_o)                 cmd_cnt_o  <= cmd_cnt_o + 32'd1;
            if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`else
    assign cmd_cnt_o  = '0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_readout_cmd_writer.sv
// Directed bench for readout_cmd_writer with a scoreboard of expected FIFO entries.
module tb_readout_cmd_writer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_tdata_i = '0;
    logic        s_tvalid_i = 1'b0;
    logic        s_tlast_i = 1'b0;
    logic        s_tready_o;
    logic        fifo_wr_en_o;
    logic        fifo_full_i = 1'b0;
    logic [82:0] fifo_din_o;
    logic        clr_err_i = 1'b0;
    logic [1:0]  err_o;
    logic [31:0] cmd_cnt_o;
    logic [15:0] drop_cnt_o;

    int errors = 0;
    int checks = 0;
    int nwr = 0;
    int exp_cmd = 0;
    int exp_drop = 0;
    logic [82:0] sb[$];

    readout_cmd_writer #(.NSAMP_MIN(2)) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i),
        .s_tready_o(s_tready_o),
        .fifo_wr_en_o(fifo_wr_en_o), .fifo_full_i(fifo_full_i), .fifo_din_o(fifo_din_o),
        .clr_err_i(clr_err_i), .err_o(err_o),
        .cmd_cnt_o(cmd_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [82:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2);
        return {w2[18], w2[17:16], w2[15:0], w1, w0};
    endfunction

    // Every FIFO write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && fifo_wr_en_o) begin
            chk("write_expected", 83'(sb.size() > 0), 83'(1));
            if (sb.size() > 0) chk("fifo_din", fifo_din_o, sb.pop_front());
            chk("write_while_full", 83'(fifo_full_i), 83'(0));
            nwr++;
        end
    end

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic clr);
        int n;
        n = 0;
        s_tdata_i  = d;
        s_tlast_i  = last;
        s_tvalid_i = 1'b1;
        clr_err_i  = clr;
        forever begin
            @(negedge clk);
            if (s_tready_o) break;
            n++;
            if (n > 50) begin
                chk("tready_timeout", 83'(s_tready_o), 83'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        clr_err_i  = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        sb.push_back(pack(w0, w1, w2));
        exp_cmd++;
        send_word(w0, 1'b0, 1'b0);
        send_word(w1, 1'b0, 1'b0);
        send_word(w2, 1'b1, 1'b0);
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (nwr < target && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("write_count", 83'(nwr), 83'(target));
    endtask

    task automatic chk_cnt();
`ifdef READOUT_CMD_WR_STATS_EN
        chk("cmd_cnt", 83'(cmd_cnt_o), 83'(exp_cmd));
        chk("drop_cnt", 83'(drop_cnt_o), 83'(exp_drop));
`else
        chk("cmd_cnt_tied", 83'(cmd_cnt_o), 83'(0));
        chk("drop_cnt_tied", 83'(drop_cnt_o), 83'(0));
`endif
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tready", 83'(s_tready_o), 83'(1));
        chk("rst_wr_en", 83'(fifo_wr_en_o), 83'(0));
        chk("rst_din", fifo_din_o, 83'(0));
        chk("rst_err", 83'(err_o), 83'(0));
        chk("rst_cmd_cnt", 83'(cmd_cnt_o), 83'(0));
        chk("rst_drop_cnt", 83'(drop_cnt_o), 83'(0));
    endtask

    initial begin
        logic [31:0] w0, w1, w2;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic command, write one cycle after word 2
        send_cmd(32'h11111111, 32'h22222222, 32'h0005_0010);
        @(negedge clk);
        chk("latency_wr_en", 83'(fifo_wr_en_o), 83'(1));
        @(posedge clk);
        #1;
        wait_writes(1);
        chk_cnt();

        // Backpressure: 5 cycles full
        fifo_full_i = 1'b1;
        send_cmd(32'h11111111, 32'h22222222, 32'h0005_0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_tready", 83'(s_tready_o), 83'(0));
            chk("full_no_wr", 83'(fifo_wr_en_o), 83'(0));
        end
        @(posedge clk);
        #1 fifo_full_i = 1'b0;
        @(negedge clk);
        chk("full_release_wr", 83'(fifo_wr_en_o), 83'(1));
        @(posedge clk);
        #1;
        wait_writes(2);
        chk_cnt();

        // tlast on word 1
        send_word(32'h33333333, 1'b0, 1'b0);
        send_word(32'h44444444, 1'b1, 1'b0);
        exp_drop++;
        chk("err_tlast_w1", 83'(err_o), 83'(2'b01));
        chk("no_write_tlast_w1", 83'(nwr), 83'(2));
        chk_cnt();
        send_cmd(32'hAAAA0001, 32'hBBBB0002, 32'h0002_0002);
        wait_writes(3);

        // Missing tlast on word 2; upper word-2 bits are ignored on the next command
        send_word(32'h55555555, 1'b0, 1'b0);
        send_word(32'h66666666, 1'b0, 1'b0);
        send_word(32'h0001_0100, 1'b0, 1'b0);
        exp_drop++;
        chk("no_write_no_tlast", 83'(nwr), 83'(3));
        send_cmd(32'hDEADBEEF, 32'hCAFEF00D, 32'hFFF8_1234);
        wait_writes(4);
        chk_cnt();

        // Clear, then nsamp below minimum
        clr_err_i = 1'b1;
        @(posedge clk);
        #1 clr_err_i = 1'b0;
        chk("err_cleared", 83'(err_o), 83'(0));
        send_word(32'h77777777, 1'b0, 1'b0);
        send_word(32'h88888888, 1'b0, 1'b0);
        send_word(32'h0000_0001, 1'b1, 1'b0);
        exp_drop++;
        chk("err_nsamp", 83'(err_o), 83'(2'b10));
        // Clear coincides with a new framing error: set wins
        send_word(32'h99999999, 1'b1, 1'b1);
        exp_drop++;
        chk("err_set_wins", 83'(err_o), 83'(2'b01));
        chk("no_write_errs", 83'(nwr), 83'(4));
        chk_cnt();

        // Reset while in PUSH
        fifo_full_i = 1'b1;
        send_word(32'h12345678, 1'b0, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0, 1'b0);
        send_word(32'h0003_0040, 1'b1, 1'b0);
        @(negedge clk);
        chk("in_push_tready", 83'(s_tready_o), 83'(0));
        #2 rstn = 1'b0;
        #1;
        chk_reset_outputs();
        exp_cmd = 0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        fifo_full_i = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_write_after_rst", 83'(nwr), 83'(4));
        send_cmd(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0004_0002);
        wait_writes(5);
        chk_cnt();

        // Ten random legal commands
        for (int i = 0; i < 10; i++) begin
            w0 = $urandom;
            w1 = $urandom;
            w2 = $urandom;
            w2[15:0] = 16'($urandom_range(2, 65535));
            send_cmd(w0, w1, w2);
        end
        wait_writes(15);
        chk_cnt();
        chk("sb_drained", 83'(sb.size()), 83'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
